// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add MAC element.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement magnitude: the operand is taken as ~x+1 when this returns 1
    function automatic logic twos_mag_sel(input logic i_sgn, input logic i_msb);
        return i_sgn & i_msb;
    endfunction

endpackage

// File: rtl/mult_seq_mac_adder_nb.sv
// Ripple-carry adder of N bits with carry-in, built from full_adder cells.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module adder_nb #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum
);
    logic [N-1:0] w_c;

    assign w_c[0] = i_cin;

    // The carry out of the top bit is never needed, so the MSB is a bare XOR
    for (genvar i = 0; i < N - 1; i++) begin : g_fa
        full_adder u_fa (
            .i_a(i_a[i]),
            .i_b(i_b[i]),
            .i_c(w_c[i]),
            .o_s(o_sum[i]),
            .o_c(w_c[i+1])
        );
    end

    assign o_sum[N-1] = i_a[N-1] ^ i_b[N-1] ^ w_c[N-1];
endmodule

// File: rtl/mult_seq_mac.sv
// Sequential shift-add multiplier (one multiplier bit per cycle) with signed mode and accumulator.
module mult_seq_mac
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [ACC_W-1:0]     acc,
    output logic [1:0]           o_dbg_state
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("mult_seq_mac: WIDTH must be >= 2");
    end
    if (ACC_W < 2 * WIDTH) begin : g_bad_acc
        $error("mult_seq_mac: ACC_W must be >= 2*WIDTH");
    end

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_mcand, r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic [PW-1:0]      r_partial, r_product;
    logic [ACC_W-1:0]   r_acc;
    logic               r_neg, r_acc_en, r_signed;

    logic               w_a_neg, w_b_neg, w_handshake_out;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [PW-1:0]      w_addend, w_partial_next, w_product_next;
    logic [ACC_W-1:0]   w_prod_ext, w_acc_base, w_acc_sum;

    // Magnitude of each operand: ~x+1 when negative, x otherwise
    assign w_a_neg = twos_mag_sel(is_signed, a[WIDTH-1]);
    assign w_b_neg = twos_mag_sel(is_signed, b[WIDTH-1]);

    adder_nb #(.N(WIDTH)) u_mag_a (
        .i_a(a ^ {WIDTH{w_a_neg}}), .i_b('0), .i_cin(w_a_neg), .o_sum(w_a_mag)
    );
    adder_nb #(.N(WIDTH)) u_mag_b (
        .i_a(b ^ {WIDTH{w_b_neg}}), .i_b('0), .i_cin(w_b_neg), .o_sum(w_b_mag)
    );

    assign w_addend = r_mplier[0] ? ({{WIDTH{1'b0}}, r_mcand} << r_cnt) : '0;

    adder_nb #(.N(PW)) u_partial_add (
        .i_a(r_partial), .i_b(w_addend), .i_cin(1'b0), .o_sum(w_partial_next)
    );
    adder_nb #(.N(PW)) u_negate (
        .i_a(w_partial_next ^ {PW{r_neg}}), .i_b('0), .i_cin(r_neg), .o_sum(w_product_next)
    );

    // A clear on the same edge as an accumulate leaves just the new product
    assign w_prod_ext = r_signed ? ACC_W'($signed(r_product)) : ACC_W'(r_product);
    assign w_acc_base = acc_clr ? '0 : r_acc;

    adder_nb #(.N(ACC_W)) u_acc_add (
        .i_a(w_acc_base), .i_b(w_prod_ext), .i_cin(1'b0), .o_sum(w_acc_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = BUSY;
            BUSY:    if (r_cnt == CNT_LAST) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    assign w_handshake_out = (r_state == DONE) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_partial <= '0;
            r_product <= '0;
            r_neg     <= 1'b0;
            r_acc_en  <= 1'b0;
            r_signed  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand   <= w_a_mag;
                        r_mplier  <= w_b_mag;
                        r_neg     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc_en  <= acc_en;
                        r_signed  <= is_signed;
                        r_partial <= '0;
                        r_cnt     <= '0;
                    end
                end
                BUSY: begin
                    r_partial <= w_partial_next;
                    r_mplier  <= r_mplier >> 1;
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) r_product <= w_product_next;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_acc <= '0;
        else if (w_handshake_out && r_acc_en) r_acc <= w_acc_sum;
        else if (acc_clr)                    r_acc <= '0;
    end

    assign product     = r_product;
    assign acc         = r_acc;
    assign o_dbg_state = r_state;

endmodule
